// File: rtl/linescanner_capture_ctrl.sv
// linescanner_capture_ctrl
// Line-scan sensor capture controller: sensor reset/sample sequencer, ADC
// load strobe generator, and a framed pixel stream with line counting and
// error flags.
// Optional macro LINESCAN_PIXEL_REG_EN: registers the pixel stream outputs
// (1-cycle latency) and runs line edge detection off the registered lval.
module linescanner_capture_ctrl #(
  parameter int DATA_WIDTH         = 8,
  parameter int CNT_WIDTH          = 8,
  parameter int RST_CVC_CYCLES     = 48,
  parameter int RST_CDS_CYCLES     = 7,
  parameter int SAMPLE_CYCLES      = 48,
  parameter int SAMPLE_TAIL_CYCLES = 6,
  parameter int LOAD_DELAY         = 3,
  parameter int LINE_PIXELS        = 1024
) (
  input  logic                  pixel_clock,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic                  continuous,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  end_adc,
  input  logic                  lval,
  output logic                  rst_cvc,
  output logic                  rst_cds,
  output logic                  sample,
  output logic                  load_pulse,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic                  line_start,
  output logic                  line_end,
  output logic [15:0]           line_count,
  output logic                  line_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int IW = $clog2(LINE_PIXELS + 1);

  // Terminal count for an N-cycle wait; N=0 is treated as a 1-cycle wait.
  function automatic logic [CNT_WIDTH-1:0] last_cnt(input int n);
    last_cnt = (n <= 1) ? '0 : CNT_WIDTH'(n - 1);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_CVC_WAIT, S_CDS_WAIT, S_WAIT_EADC, S_SAMPLE_HI, S_TAIL, S_RELEASE
  } seq_t;

  typedef enum logic [2:0] {
    LD_IDLE, LD_LVAL, LD_DELAY, LD_PULSE, LD_EADC_FE
  } ld_t;

  seq_t                 state, state_nx;
  ld_t                  ld_state, ld_nx;
  logic [CNT_WIDTH-1:0] cnt, ld_cnt;
  logic                 end_adc_q;
  logic                 end_adc_rise;

  assign end_adc_rise = end_adc && !end_adc_q;

  // ---------------- sensor sequencer ----------------

  // Sequencer state register and shared wait counter (cleared on state change).
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
    end
  end

  // Sequencer next state; enable is only consulted in IDLE so a started
  // integration always runs through RELEASE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (enable && (continuous || start))    state_nx = S_CVC_WAIT;
      S_CVC_WAIT:  if (cnt == last_cnt(RST_CVC_CYCLES))     state_nx = S_CDS_WAIT;
      S_CDS_WAIT:  if (cnt == last_cnt(RST_CDS_CYCLES))     state_nx = S_WAIT_EADC;
      S_WAIT_EADC: if (end_adc)                             state_nx = S_SAMPLE_HI;
      S_SAMPLE_HI: if (cnt == last_cnt(SAMPLE_CYCLES))      state_nx = S_TAIL;
      S_TAIL:      if (cnt == last_cnt(SAMPLE_TAIL_CYCLES)) state_nx = S_RELEASE;
      S_RELEASE:                                            state_nx = S_IDLE;
      default:                                              state_nx = S_IDLE;
    endcase
  end

  // Sensor pins decoded from the sequencer state.
  always_comb begin
    rst_cvc = 1'b1;
    rst_cds = 1'b1;
    sample  = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_CVC_WAIT:  rst_cvc = 1'b0;
      S_CDS_WAIT,
      S_WAIT_EADC,
      S_TAIL:      begin rst_cvc = 1'b0; rst_cds = 1'b0; end
      S_SAMPLE_HI: begin rst_cvc = 1'b0; rst_cds = 1'b0; sample = 1'b1; end
      default:     ;
    endcase
  end

  // ---------------- load strobe FSM ----------------

  // Load FSM state register with its own delay counter.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      ld_state <= LD_IDLE;
      ld_cnt   <= '0;
    end else begin
      ld_state <= ld_nx;
      ld_cnt   <= (ld_nx != ld_state) ? '0 : ld_cnt + 1'b1;
    end
  end

  // Load FSM next state: conversion done, line drained, delay, strobe, re-arm.
  always_comb begin
    ld_nx = ld_state;
    case (ld_state)
      LD_IDLE:    if (end_adc)                          ld_nx = LD_LVAL;
      LD_LVAL:    if (!lval)                            ld_nx = LD_DELAY;
      LD_DELAY:   if (ld_cnt == last_cnt(LOAD_DELAY))   ld_nx = LD_PULSE;
      LD_PULSE:                                         ld_nx = LD_EADC_FE;
      LD_EADC_FE: if (!end_adc)                         ld_nx = LD_IDLE;
      default:                                          ld_nx = LD_IDLE;
    endcase
  end

  // Registered load strobe, one cycle per visit to LD_PULSE.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) load_pulse <= 1'b0;
    else          load_pulse <= (ld_state == LD_PULSE);
  end

  // Overrun: a new conversion finished before the previous load completed.
  // Cleared only while the sequencer is parked with enable low.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      end_adc_q <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      end_adc_q <= end_adc;
      if (!enable && state == S_IDLE)            overrun <= 1'b0;
      else if (end_adc_rise && ld_state != LD_IDLE) overrun <= 1'b1;
    end
  end

  // ---------------- pixel stream ----------------

  logic                  lv, lv_q, line_fall, long_line;
  logic [DATA_WIDTH-1:0] data_hold;
  logic [IW-1:0]         pix_cnt;

  // Last valid pixel, held while lval is low.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset)  data_hold <= '0;
    else if (lval) data_hold <= data;
  end

`ifdef LINESCAN_PIXEL_REG_EN
  logic lval_r;

  // Registered line-valid; the whole stream runs one cycle behind the pins.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) lval_r <= 1'b0;
    else          lval_r <= lval;
  end

  assign lv         = lval_r;
  assign pixel_data = data_hold;
`else
  assign lv         = lval;
  assign pixel_data = lval ? data : data_hold;
`endif

  assign pixel_valid = lv;
  assign line_start  = lv && (pix_cnt == '0);
  assign line_end    = lv && (pix_cnt == IW'(LINE_PIXELS - 1));
  assign line_fall   = lv_q && !lv;

  // Pixel index of the current pixel: zero between lines, saturating at
  // LINE_PIXELS; long_line remembers pixels beyond the saturation point.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      lv_q      <= 1'b0;
      pix_cnt   <= '0;
      long_line <= 1'b0;
    end else begin
      lv_q <= lv;
      if (!lv) begin
        pix_cnt   <= '0;
        long_line <= 1'b0;
      end else if (pix_cnt != IW'(LINE_PIXELS)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end else begin
        long_line <= 1'b1;
      end
    end
  end

  // Line completion on lval falling edge: count it and flag a bad length.
  always_ff @(posedge pixel_clock or negedge n_reset) begin
    if (!n_reset) begin
      line_count <= '0;
      line_err   <= 1'b0;
    end else begin
      line_err <= line_fall && ((pix_cnt != IW'(LINE_PIXELS)) || long_line);
      if (line_fall) line_count <= line_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_linescanner_capture_ctrl.sv
// Directed bench for linescanner_capture_ctrl (default build, LINE_PIXELS=8).
module tb_linescanner_capture_ctrl;
  localparam int LP = 8;

  logic       pixel_clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       enable = 1'b0, continuous = 1'b0, start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       end_adc = 1'b0, lval = 1'b0;
  logic       rst_cvc, rst_cds, sample, load_pulse;
  logic [7:0] pixel_data;
  logic       pixel_valid, line_start, line_end;
  logic [15:0] line_count;
  logic       line_err, overrun, busy;

  linescanner_capture_ctrl #(.LINE_PIXELS(LP)) dut (
    .pixel_clock(pixel_clock), .n_reset(n_reset), .enable(enable),
    .continuous(continuous), .start(start), .data(data), .end_adc(end_adc),
    .lval(lval), .rst_cvc(rst_cvc), .rst_cds(rst_cds), .sample(sample),
    .load_pulse(load_pulse), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .line_start(line_start), .line_end(line_end), .line_count(line_count),
    .line_err(line_err), .overrun(overrun), .busy(busy)
  );

  always #5 pixel_clock = ~pixel_clock;

  int cyc = 0;
  always @(posedge pixel_clock) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rise(output int ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (sample === 1'b1) begin ok = 1; break; end
      @(negedge pixel_clock);
    end
  endtask

  initial begin
    int n, ok, errs;
    int rise [3];

    // reset values
    #1;
    chk("rst_rst_cvc", rst_cvc, 1);
    chk("rst_rst_cds", rst_cds, 1);
    chk("rst_sample", sample, 0);
    chk("rst_load_pulse", load_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_pixel_data", pixel_data, 0);
    repeat (2) @(negedge pixel_clock);
    n_reset = 1'b1; enable = 1'b1;
    @(negedge pixel_clock);

    // single shot
    start = 1'b1;
    @(negedge pixel_clock);
    start = 1'b0;
    chk("ss_busy", busy, 1);
    chk("ss_cvc_fall", rst_cvc, 0);
    n = 0;
    while (rst_cds === 1'b1 && n < 500) begin n++; @(negedge pixel_clock); end
    chk("ss_cvc_len", n, 48);
    repeat (17) @(negedge pixel_clock);
    chk("ss_wait_no_sample", sample, 0);
    chk("ss_wait_busy", busy, 1);
    end_adc = 1'b1;
    @(negedge pixel_clock);
    n = 0;
    while (sample === 1'b1 && n < 500) begin n++; @(negedge pixel_clock); end
    chk("ss_sample_len", n, 48);
    n = 0;
    while (rst_cvc === 1'b0 && n < 500) begin n++; @(negedge pixel_clock); end
    chk("ss_tail_len", n, 6);
    chk("ss_release_cds", rst_cds, 1);
    @(negedge pixel_clock);
    chk("ss_idle", busy, 0);
    end_adc = 1'b0;
    ok = 1;
    repeat (30) begin @(negedge pixel_clock); if (busy !== 1'b0) ok = 0; end
    chk("ss_no_rerun", ok, 1);

    // continuous mode
    continuous = 1'b1; end_adc = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rise(ok);
      chk("cont_rise", ok, 1);
      rise[k] = cyc;
      n = 0;
      while (sample === 1'b1 && n < 500) begin n++; @(negedge pixel_clock); end
      chk("cont_width", n, 48);
    end
    chk("cont_period1", rise[1] - rise[0], 112);
    chk("cont_period2", rise[2] - rise[1], 112);
    wait_rise(ok);
    chk("cont_rise4", ok, 1);
    n = 0;
    while (sample === 1'b1 && n < 500) begin
      if (n == 10) begin enable = 1'b0; continuous = 1'b0; end
      n++; @(negedge pixel_clock);
    end
    chk("cont_drop_width", n, 48);
    repeat (10) @(negedge pixel_clock);
    chk("cont_drop_idle", busy, 0);
    chk("cont_drop_rst", rst_cvc, 1);
    ok = 1;
    repeat (150) begin @(negedge pixel_clock); if (sample !== 1'b0 || busy !== 1'b0) ok = 0; end
    chk("cont_stays_idle", ok, 1);
    end_adc = 1'b0; enable = 1'b1;
    repeat (5) @(negedge pixel_clock);

    // load pulse (overlong line as a side effect)
    lval = 1'b1; data = 8'hAA;
    @(negedge pixel_clock);
    end_adc = 1'b1;
    repeat (20) @(negedge pixel_clock);
    lval = 1'b0;
    n = 0;
    while (load_pulse !== 1'b1 && n < 50) begin @(negedge pixel_clock); n++; end
    chk("ld_delay", n, 5);
    @(negedge pixel_clock);
    chk("ld_one_cycle", load_pulse, 0);
    chk("ld_line_count", line_count, 1);
    chk("ld_no_overrun", overrun, 0);
    chk("ld_hold", pixel_data, 8'hAA);
    end_adc = 1'b0;
    repeat (3) @(negedge pixel_clock);

    // 8-pixel line
    for (int i = 0; i < LP; i++) begin
      data = 8'(8'h10 + i); lval = 1'b1;
      #1;
      chk("px_valid", pixel_valid, 1);
      chk("px_data", pixel_data, 8'h10 + i);
      chk("px_start", line_start, (i == 0));
      chk("px_end", line_end, (i == LP - 1));
      @(negedge pixel_clock);
    end
    lval = 1'b0; data = 8'h55;
    #1;
    chk("px_valid_low", pixel_valid, 0);
    chk("px_hold", pixel_data, 8'h17);
    errs = 0;
    repeat (4) begin @(negedge pixel_clock); if (line_err === 1'b1) errs++; end
    chk("px8_no_err", errs, 0);
    chk("px8_count", line_count, 2);

    // 5-pixel line
    repeat (5) begin lval = 1'b1; @(negedge pixel_clock); end
    lval = 1'b0;
    errs = 0;
    repeat (4) begin @(negedge pixel_clock); if (line_err === 1'b1) errs++; end
    chk("px5_err_once", errs, 1);
    chk("px5_count", line_count, 3);

    // overrun
    chk("ovr_clear_before", overrun, 0);
    end_adc = 1'b1;
    @(negedge pixel_clock);
    end_adc = 1'b0;
    @(negedge pixel_clock);
    end_adc = 1'b1;
    @(negedge pixel_clock);
    chk("ovr_set", overrun, 1);
    repeat (10) @(negedge pixel_clock);
    end_adc = 1'b0;
    repeat (3) @(negedge pixel_clock);
    repeat (LP) begin lval = 1'b1; @(negedge pixel_clock); end
    lval = 1'b0;
    repeat (3) @(negedge pixel_clock);
    chk("ovr_hold", overrun, 1);
    chk("ovr_line_count", line_count, 4);
    enable = 1'b0;
    @(negedge pixel_clock);
    chk("ovr_cleared", overrun, 0);
    enable = 1'b1;
    @(negedge pixel_clock);

    // async reset during SAMPLE_HI, then full rerun
    start = 1'b1; end_adc = 1'b1;
    @(negedge pixel_clock);
    start = 1'b0;
    wait_rise(ok);
    chk("ar_rise", ok, 1);
    repeat (5) @(negedge pixel_clock);
    n_reset = 1'b0;
    #1;
    chk("ar_sample", sample, 0);
    chk("ar_rst_cvc", rst_cvc, 1);
    chk("ar_rst_cds", rst_cds, 1);
    chk("ar_line_count", line_count, 0);
    chk("ar_busy", busy, 0);
    @(negedge pixel_clock);
    n_reset = 1'b1;
    @(negedge pixel_clock);
    start = 1'b1;
    @(negedge pixel_clock);
    start = 1'b0;
    chk("ar2_cvc_fall", rst_cvc, 0);
    n = 0;
    while (rst_cds === 1'b1 && n < 500) begin n++; @(negedge pixel_clock); end
    chk("ar2_cvc_len", n, 48);
    wait_rise(ok);
    chk("ar2_rise", ok, 1);
    n = 0;
    while (sample === 1'b1 && n < 500) begin n++; @(negedge pixel_clock); end
    chk("ar2_sample_len", n, 48);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge pixel_clock); end
    chk("ar2_back_idle", busy, 0);
    end_adc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
